// File: rtl/clk_div_pkg.sv
// ============================================================================
// clk_div_pkg : shared types and defaults for the clock divider controller
// Revision    : 1.0
// ============================================================================
`default_nettype none

package clk_div_pkg;

  localparam int CNT_W_DEFAULT        = 24;
  localparam int DEFAULT_HALF_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/clk_div_core.sv
// ============================================================================
// clk_div_core : half-period counter producing the divided clock and tick
// Revision     : 1.0
// ============================================================================
`default_nettype none

module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] half_i,
  output logic             clk_out_o,
  output logic             tick_o,
  output logic             fall_o
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             wrap;

  assign wrap = (cnt_q == (half_i - ONE));

  always_comb begin
    cnt_d  = cnt_q;
    clk_d  = clk_q;
    tick_d = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
      clk_d = 1'b0;
    end else if (en_i) begin
      if (wrap) begin
        cnt_d  = '0;
        clk_d  = ~clk_q;
        tick_d = ~clk_q;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  // Marks the edge at which the high phase ends: the full-period boundary.
  assign fall_o    = en_i && !clr_i && wrap && clk_q;
  assign clk_out_o = clk_q;
  assign tick_o    = tick_q;

endmodule

`default_nettype wire

// File: rtl/clk_div_ctrl.sv
// ============================================================================
// clk_div_ctrl : run/stop sequencing and boundary-safe reconfiguration of the
//                programmable clock divider
// Revision     : 1.0
// ============================================================================
`default_nettype none

module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEFAULT,
  parameter int DEFAULT_HALF = DEFAULT_HALF_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  input  logic             start,
  input  logic             stop,
  output logic             clk_out,
  output logic             tick,
  output logic             running,
  output logic             cfg_pending
);

  localparam logic [CNT_W-1:0] ONE        = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] RESET_HALF = CNT_W'(DEFAULT_HALF);

  state_e           state_q;
  logic [CNT_W-1:0] active_half_q;
  logic [CNT_W-1:0] pend_half_q;
  logic             pend_flag_q;

  logic             core_en;
  logic             core_clr;
  logic             core_fall;
  logic             cfg_acc;
  logic             to_idle;
  logic [CNT_W-1:0] cfg_clamped;

  assign cfg_ready   = !pend_flag_q;
  assign cfg_pending = pend_flag_q;
  assign running     = (state_q != ST_IDLE);
  assign cfg_acc     = cfg_valid && cfg_ready;
  assign cfg_clamped = (cfg_half == '0) ? ONE : cfg_half;

  assign core_en  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  // Stop during the low phase aborts at once; the counter is cleared.
  assign core_clr = (state_q == ST_IDLE) || ((state_q == ST_RUN) && stop && !clk_out);

  assign to_idle = ((state_q == ST_RUN) && stop && (!clk_out || core_fall)) ||
                   ((state_q == ST_DRAIN) && core_fall);

  clk_div_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .en_i      (core_en),
    .clr_i     (core_clr),
    .half_i    (active_half_q),
    .clk_out_o (clk_out),
    .tick_o    (tick),
    .fall_o    (core_fall)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      active_half_q <= RESET_HALF;
      pend_half_q   <= '0;
      pend_flag_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !stop) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (to_idle)   state_q <= ST_IDLE;
          else if (stop) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (core_fall) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase

      // A config arriving while stopping is applied directly, never left pending in IDLE.
      if (pend_flag_q && (core_fall || to_idle)) begin
        active_half_q <= pend_half_q;
        pend_flag_q   <= 1'b0;
      end else if (cfg_acc) begin
        if ((state_q == ST_IDLE) || to_idle) begin
          active_half_q <= cfg_clamped;
        end else begin
          pend_half_q <= cfg_clamped;
          pend_flag_q <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
// ============================================================================
// tb_clk_div_ctrl : directed and random checks of clk_div_ctrl against a
//                   phase-countdown reference model
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_clk_div_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic [23:0] cfg_half;
  logic        cfg_ready;
  logic        start;
  logic        stop;
  logic        clk_out;
  logic        tick;
  logic        running;
  logic        cfg_pending;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 idle, 1 run, 2 drain; m_left = edges until next toggle.
  int   m_mode;
  logic m_clk;
  logic m_tick;
  int   m_half;
  int   m_pend;
  logic m_pv;
  int   m_left;

  clk_div_ctrl #(
    .CNT_W        (24),
    .DEFAULT_HALF (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_valid   (cfg_valid),
    .cfg_half    (cfg_half),
    .cfg_ready   (cfg_ready),
    .start       (start),
    .stop        (stop),
    .clk_out     (clk_out),
    .tick        (tick),
    .running     (running),
    .cfg_pending (cfg_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_clk  = 1'b0;
    m_tick = 1'b0;
    m_half = 4;
    m_pend = 0;
    m_pv   = 1'b0;
    m_left = 0;
  endtask

  task automatic model_edge();
    int   nh;
    int   mode_n;
    logic acc, tog, fall_e, to_idle, cleared;
    if (!reset) begin
      model_reset();
      return;
    end
    nh      = (cfg_half == 24'd0) ? 1 : int'(cfg_half);
    acc     = cfg_valid && !m_pv;
    tog     = (m_mode != 0) && (m_left == 1);
    fall_e  = tog && m_clk;
    cleared = 1'b0;
    to_idle = 1'b0;
    mode_n  = m_mode;
    case (m_mode)
      0: if (start && !stop) mode_n = 1;
      1: begin
        if (stop && !m_clk) begin
          to_idle = 1'b1;
          cleared = 1'b1;
        end else if (stop && fall_e) begin
          to_idle = 1'b1;
        end else if (stop) begin
          mode_n = 2;
        end
      end
      default: if (fall_e) to_idle = 1'b1;
    endcase
    if (to_idle) mode_n = 0;

    if (m_pv && (fall_e || to_idle)) begin
      m_half = m_pend;
      m_pv   = 1'b0;
    end else if (acc) begin
      if (m_mode == 0 || to_idle) m_half = nh;
      else begin
        m_pend = nh;
        m_pv   = 1'b1;
      end
    end

    m_tick = 1'b0;
    if (cleared) begin
      m_clk = 1'b0;
    end else if (tog) begin
      m_tick = !m_clk;
      m_clk  = !m_clk;
      m_left = m_half;
    end else if (m_mode != 0) begin
      m_left--;
    end
    if (m_mode == 0 && mode_n == 1) m_left = m_half;
    m_mode = mode_n;
  endtask

  task automatic compare_all();
    chk("clk_out", 32'(clk_out), 32'(m_clk));
    chk("tick", 32'(tick), 32'(m_tick));
    chk("running", 32'(running), 32'(m_mode != 0));
    chk("cfg_ready", 32'(cfg_ready), 32'(!m_pv));
    chk("cfg_pending", 32'(cfg_pending), 32'(m_pv));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wait_tick(input int limit, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!tick && n < limit);
  endtask

  task automatic offer_idle_cfg(input logic [23:0] h);
    cfg_valid = 1'b1;
    cfg_half  = h;
    cyc();
    cfg_valid = 1'b0;
  endtask

  initial begin
    int n;
    int guard;
    reset     = 1'b0;
    cfg_valid = 1'b0;
    cfg_half  = '0;
    start     = 1'b0;
    stop      = 1'b0;
    model_reset();

    // Reset and idle quiet period
    cycles(3);
    chk("rst_clk_out", 32'(clk_out), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_cfg_pending", 32'(cfg_pending), 32'd0);
    reset = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (tick) n++;
    end
    chk("idle_no_tick", 32'(n), 32'd0);

    // Basic run with default H=4
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_tick(20, n);
    chk("first_rise", 32'(n), 32'd4);
    for (int p = 0; p < 5; p++) begin
      wait_tick(20, n);
      chk("period_h4", 32'(n), 32'd8);
    end

    // Reconfigure to 2 while high at cnt=1; second offer must be held
    n = 1;
    cyc();
    if (clk_out) n++;
    cfg_valid = 1'b1;
    cfg_half  = 24'd2;
    cyc();
    if (clk_out) n++;
    chk("cfg_ready_low", 32'(cfg_ready), 32'd0);
    cfg_half = 24'd7;
    guard = 0;
    while (clk_out && guard < 20) begin
      chk("held_cfg_ready", 32'(cfg_ready), 32'd0);
      cyc();
      if (clk_out) n++;
      guard++;
    end
    cfg_valid = 1'b0;
    chk("high_phase_len", 32'(n), 32'd4);
    chk("ready_after_fall", 32'(cfg_ready), 32'd1);
    wait_tick(20, n);
    chk("low_phase_h2", 32'(n), 32'd2);
    wait_tick(20, n);
    chk("period_h2", 32'(n), 32'd4);

    // Stop while high with H=6 at cnt=2
    cfg_valid = 1'b1;
    cfg_half  = 24'd6;
    cyc();
    cfg_valid = 1'b0;
    guard = 0;
    while (cfg_pending && guard < 20) begin
      cyc();
      guard++;
    end
    chk("pend_applied", 32'(cfg_pending), 32'd0);
    wait_tick(30, n);
    cycles(2);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    n = 0;
    guard = 0;
    while (clk_out && guard < 20) begin
      n++;
      cyc();
      guard++;
    end
    chk("drain_high_cycles", 32'(n), 32'd3);
    chk("running_at_fall", 32'(running), 32'd0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (tick) n++;
    end
    chk("no_tick_after_stop", 32'(n), 32'd0);

    // Zero clamp
    offer_idle_cfg(24'd0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_tick(10, n);
    chk("h1_first_rise", 32'(n), 32'd1);
    for (int p = 0; p < 3; p++) begin
      wait_tick(10, n);
      chk("h1_period", 32'(n), 32'd2);
    end
    stop = 1'b1;
    cycles(2);
    stop = 1'b0;
    cycles(2);

    // Simultaneous start and stop in idle
    start = 1'b1;
    stop  = 1'b1;
    cycles(3);
    chk("start_stop_idle", 32'(running), 32'd0);
    start = 1'b0;
    stop  = 1'b0;

    // Asynchronous reset mid-run with H=3
    offer_idle_cfg(24'd3);
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_tick(20, n);
    chk("h3_first_rise", 32'(n), 32'd3);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("async_rst_clk_out", 32'(clk_out), 32'd0);
    chk("async_rst_running", 32'(running), 32'd0);
    compare_all();
    cycles(2);
    reset = 1'b1;
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_tick(20, n);
    chk("default_half_restored", 32'(n), 32'd4);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      start     = ($urandom_range(0, 3) == 0);
      stop      = ($urandom_range(0, 11) == 0);
      cfg_valid = ($urandom_range(0, 5) == 0);
      cfg_half  = 24'($urandom_range(0, 5));
      cyc();
    end
    start     = 1'b0;
    stop      = 1'b0;
    cfg_valid = 1'b0;
    cycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
